uart_avalon_bridge: RTL and testbench
=====================================

UART_AVALON_BRIDGE -- requirements
Module: uart_avalon_bridge

Interface
REQ-001 Parameter CLKS_PER_BIT, 434, CLK cycles per UART bit (min 8).
REQ-002 Parameter DATA_W, 32, Avalon data width; multiple of 8, range 8..64; NB = DATA_W/8.
REQ-003 Parameter NUM_REGS, 4, addressable words (1..128).
REQ-004 Parameter BASE_ADDR, 32'h0, byte address of word 0.
REQ-005 Parameter TX_DEPTH, 16, TX FIFO bytes; power of 2, >= NB+1.
REQ-006 Parameter TIMEOUT_BITS, 20, inter-byte timeout in bit-times.
REQ-007 CLK  in  1  single clock; all logic on rising edge.
REQ-008 RST_N  in  1  reset, synchronous, active-low.
REQ-009 RX  in  1  UART serial input, idle high; synchronised by 2 flops.
REQ-010 TX  out  1  UART serial output, idle high.
REQ-011 ADDRESS  out  32  Avalon byte address.
REQ-012 READ / WRITE  out  1 each  Avalon strobes, never both high.
REQ-013 WRITEDATA  out  DATA_W  write data.
REQ-014 BYTEENABLE  out  NB  all ones during any access.
REQ-015 READDATA  in  DATA_W  read data, sampled when READ=1 and WAITREQUEST=0.
REQ-016 WAITREQUEST  in  1  slave stall.
REQ-017 BUSY  out  1  high whenever frame FSM not in S_HDR or TX FIFO non-empty.
REQ-018 ERR_CNT  out  8  saturating error counter.

Function
REQ-019 Frame: header byte {rnw[7], idx[6:0]}; write frames follow with NB data bytes, LSB first; read frames have no payload.
REQ-020 ADDRESS = BASE_ADDR + idx*NB, 32-bit wrap-around.
REQ-021 FSM states S_HDR, S_DATA, S_WAITSPACE, S_BUS, S_RESP; reset state S_HDR.
REQ-022 S_HDR -> S_DATA on write header; -> S_WAITSPACE on read header.
REQ-023 S_DATA collects NB bytes, then -> S_WAITSPACE.
REQ-024 S_WAITSPACE -> S_BUS once TX FIFO free space >= NB (read) or >= 1 (write/error); holds otherwise (backpressure, no byte loss beyond 1 byte RX holding register).
REQ-025 S_BUS asserts READ or WRITE with stable ADDRESS/WRITEDATA until the first cycle WAITREQUEST=0; strobe drops the following cycle; -> S_RESP.
REQ-026 S_RESP pushes response into TX FIFO: write = 1 byte 8'hA5; read = NB bytes of READDATA, LSB first, one per cycle; -> S_HDR.
REQ-027 idx >= NUM_REGS: no bus access; write payload still consumed; response 8'hEE; ERR_CNT+1.
REQ-028 RX stop bit sampled 0: byte discarded, frame aborted to S_HDR, ERR_CNT+1.
REQ-029 In S_DATA, no new byte within TIMEOUT_BITS*CLKS_PER_BIT cycles: abort to S_HDR, ERR_CNT+1.
REQ-030 ERR_CNT saturates at 8'hFF; simultaneous error events in one cycle count once.
REQ-031 RX byte arriving while FSM in S_WAITSPACE/S_BUS/S_RESP is held (1 deep); a second arrival overwrites it and counts as error.
REQ-032 TX FIFO full: push never occurs (guaranteed by REQ-024); TX serialiser pops when idle, 8N1, LSB first.
REQ-033 Bus latency: READ/WRITE asserted 1 cycle after entering S_BUS; with WAITREQUEST=0 strobe lasts exactly 1 cycle.

Reset
REQ-034 While RST_N=0 at a rising edge: FSM S_HDR, FIFO empty, TX=1, READ=WRITE=0, ADDRESS=0, WRITEDATA=0, BYTEENABLE=0, BUSY=0, ERR_CNT=0, timeout counter 0.
REQ-035 Reset mid-access drops READ/WRITE at the next edge; the in-flight frame is discarded with no response.

Structure
REQ-036 Shared package uart_avalon_pkg holds FSM state enum, 8'hA5/8'hEE response constants, header field widths.
REQ-037 One sub-module uart_phy (CLKS_PER_BIT): RX deserialiser with framing-error flag, TX serialiser with ready; FIFO inline.

Verification
REQ-038 Write 0x01 + bytes 78 56 34 12 -> WRITE=1, ADDRESS=0x4, WRITEDATA=0x12345678; TX returns A5.
REQ-039 Read 0x82, READDATA=0xDEADBEEF, WAITREQUEST high 5 cycles -> READ held 6 cycles, ADDRESS=0x8; TX returns EF BE AD DE.
REQ-040 Header 0x85 (idx 5 >= 4) -> no READ/WRITE; TX returns EE; ERR_CNT=1.
REQ-041 Write header then 2 bytes, line idle 25 bit-times -> abort, ERR_CNT=1, next valid frame succeeds.
REQ-042 Stop bit forced 0 on a data byte -> frame aborted, ERR_CNT+1; ERR_CNT stays 0xFF after 300 errors.
REQ-043 RST_N low during WAITREQUEST-stalled READ -> READ=0 next edge, no TX bytes, BUSY=0.

Source files
------------

// File: rtl/uart_avalon_pkg.sv
// Shared definitions for the UART-to-Avalon bridge: frame FSM encoding,
// response byte values and header field layout.
package uart_avalon_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_HDR       = 3'd0;
  localparam state_t S_DATA      = 3'd1;
  localparam state_t S_WAITSPACE = 3'd2;
  localparam state_t S_BUS       = 3'd3;
  localparam state_t S_RESP      = 3'd4;

  localparam logic [7:0] RESP_OK  = 8'hA5;
  localparam logic [7:0] RESP_ERR = 8'hEE;

  // Header byte layout: {rnw, idx[6:0]}
  localparam int RNW_BIT = 7;
  localparam int IDX_W   = 7;

endpackage

// File: rtl/uart_avalon_bridge_if.sv
// Avalon-MM master-side signal bundle driven by the bridge.
interface uart_avalon_bridge_if #(
  parameter int DATA_W = 32
) ();
  localparam int NB = DATA_W / 8;

  logic [31:0]       address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [NB-1:0]     byteenable;
  logic [DATA_W-1:0] readdata;
  logic              waitrequest;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, waitrequest
  );
endinterface

// File: rtl/uart_phy.sv
// 8N1 UART physical layer: 2-flop synchronised receiver with framing-error
// flag, and a transmitter that accepts a byte whenever it is idle.
module uart_phy #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       tx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_ferr,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic          rx_meta_q, rx_meta_d;
  logic          rx_sync_q, rx_sync_d;
  logic          rx_prev_q, rx_prev_d;
  logic [1:0]    rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_ferr_q, rx_ferr_d;

  logic          tx_busy_q, tx_busy_d;
  logic [8:0]    tx_sh_q, tx_sh_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic          tx_q, tx_d;

  // Receiver: falling edge starts a frame, bits sampled mid-cell. Edge (not
  // level) detection keeps a low stop bit from looking like a new start.
  always_comb begin
    rx_meta_d  = rx;
    rx_sync_d  = rx_meta_q;
    rx_prev_d  = rx_sync_q;
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_st_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_st_d  = RX_START;
          rx_cnt_d = HALF_LAST;
        end
      end
      RX_START: begin
        if (rx_cnt_q != '0) begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end else if (!rx_sync_q) begin
          rx_st_d  = RX_DATA;
          rx_cnt_d = BIT_LAST;
          rx_bit_d = 3'd0;
        end else begin
          rx_st_d = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q != '0) begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end else begin
          rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
          rx_cnt_d = BIT_LAST;
          if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
          else                  rx_bit_d = rx_bit_q + 3'd1;
        end
      end
      default: begin
        if (rx_cnt_q != '0) begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end else begin
          rx_st_d = RX_IDLE;
          if (rx_sync_q) rx_valid_d = 1'b1;
          else           rx_ferr_d  = 1'b1;
        end
      end
    endcase
  end

  // Transmitter: start bit driven on load, then data LSB first, then stop.
  always_comb begin
    tx_busy_d = tx_busy_q;
    tx_sh_d   = tx_sh_q;
    tx_cnt_d  = tx_cnt_q;
    tx_bit_d  = tx_bit_q;
    tx_d      = tx_q;
    if (!tx_busy_q) begin
      if (tx_valid) begin
        tx_busy_d = 1'b1;
        tx_sh_d   = {1'b1, tx_data};
        tx_d      = 1'b0;
        tx_cnt_d  = BIT_LAST;
        tx_bit_d  = 4'd0;
      end
    end else if (tx_cnt_q != '0) begin
      tx_cnt_d = tx_cnt_q - CNT_ONE;
    end else if (tx_bit_q == 4'd9) begin
      tx_busy_d = 1'b0;
      tx_d      = 1'b1;
    end else begin
      tx_bit_d = tx_bit_q + 4'd1;
      tx_d     = tx_sh_q[0];
      tx_sh_d  = {1'b1, tx_sh_q[8:1]};
      tx_cnt_d = BIT_LAST;
    end
  end

  // State registers with synchronous reset; line side idles high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_st_q    <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      tx_busy_q  <= 1'b0;
      tx_sh_q    <= '1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_q       <= 1'b1;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      rx_prev_q  <= rx_prev_d;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
      tx_busy_q  <= tx_busy_d;
      tx_sh_q    <= tx_sh_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_q       <= tx_d;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_sh_q;
  assign rx_ferr  = rx_ferr_q;
  assign tx       = tx_q;
  assign tx_ready = !tx_busy_q;

endmodule

// File: rtl/uart_avalon_bridge.sv
// UART frame decoder driving a single-beat Avalon-MM master, with a TX FIFO
// carrying the response bytes back to the host.
//
//   state       | meaning
//   S_HDR       | waiting for header byte {rnw, idx}
//   S_DATA      | collecting write payload bytes, LSB first, with timeout
//   S_WAITSPACE | waiting until the TX FIFO can take the whole response
//   S_BUS       | Avalon strobe issued and held until waitrequest low
//   S_RESP      | pushing response byte(s) into the TX FIFO
module uart_avalon_bridge
  import uart_avalon_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          DATA_W       = 32,
  parameter int          NUM_REGS     = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int          TX_DEPTH     = 16,
  parameter int          TIMEOUT_BITS = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 tx,
  output logic                 busy,
  output logic [7:0]           err_cnt,
  uart_avalon_bridge_if.master av
);
  localparam int NB = DATA_W / 8;
  localparam int AW = $clog2(TX_DEPTH);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
  localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);
  localparam logic [3:0]  CNT_LAST = 4'(NB - 1);

  logic       rx_valid, rx_ferr, tx_ready, tx_valid;
  logic [7:0] rx_data, tx_byte;

  state_t            state_q, state_d;
  logic              rnw_q, rnw_d;
  logic              bad_q, bad_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       tmo_q, tmo_d;
  logic              hold_valid_q, hold_valid_d;
  logic [7:0]        hold_data_q, hold_data_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [NB-1:0]     be_q, be_d;
  logic [7:0]        err_q, err_d;
  logic [AW:0]       wptr_q, wptr_d;
  logic [AW:0]       rptr_q, rptr_d;
  logic [7:0]        fifo_mem_q [TX_DEPTH];

  logic        in_valid, err_evt, push, pop, empty, space_ok;
  logic [7:0]  in_byte, push_data;
  logic [AW:0] fill;

  uart_phy #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_phy (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .tx       (tx),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ferr  (rx_ferr),
    .tx_valid (tx_valid),
    .tx_data  (tx_byte),
    .tx_ready (tx_ready)
  );

  assign fill     = wptr_q - rptr_q;
  assign empty    = (fill == '0);
  assign tx_valid = !empty;
  assign tx_byte  = fifo_mem_q[rptr_q[AW-1:0]];
  assign pop      = tx_valid && tx_ready;
  assign space_ok = (rnw_q && !bad_q) ? (32'(fill) <= 32'(TX_DEPTH - NB))
                                      : (32'(fill) <= 32'(TX_DEPTH - 1));

  // Byte routing, frame FSM, bus handshake, response generation and error count.
  always_comb begin
    state_d      = state_q;
    rnw_d        = rnw_q;
    bad_d        = bad_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    read_d       = read_q;
    write_d      = write_q;
    be_d         = be_q;
    err_d        = err_q;
    in_valid     = 1'b0;
    in_byte      = hold_data_q;
    err_evt      = rx_ferr;
    push         = 1'b0;
    push_data    = RESP_OK;

    // Outside header/payload collection an arriving byte waits in a single
    // holding slot; the slot drains first once collection resumes.
    if (state_q == S_HDR || state_q == S_DATA) begin
      if (hold_valid_q) begin
        in_valid     = 1'b1;
        hold_valid_d = rx_valid;
        if (rx_valid) hold_data_d = rx_data;
      end else if (rx_valid) begin
        in_valid = 1'b1;
        in_byte  = rx_data;
      end
    end else if (rx_valid) begin
      if (hold_valid_q) err_evt = 1'b1;
      hold_valid_d = 1'b1;
      hold_data_d  = rx_data;
    end

    case (state_q)
      S_HDR: begin
        if (!rx_ferr && in_valid) begin
          rnw_d  = in_byte[RNW_BIT];
          bad_d  = 32'(in_byte[IDX_W-1:0]) >= 32'(NUM_REGS);
          addr_d = BASE_ADDR + 32'(in_byte[IDX_W-1:0]) * 32'(NB);
          cnt_d  = 4'd0;
          if (in_byte[RNW_BIT]) begin
            state_d = S_WAITSPACE;
          end else begin
            state_d = S_DATA;
            tmo_d   = TMO_LAST;
          end
        end
      end
      S_DATA: begin
        if (rx_ferr) begin
          state_d = S_HDR;
          tmo_d   = '0;
        end else if (in_valid) begin
          wdata_d = (wdata_q >> 8) | (DATA_W'(in_byte) << (DATA_W - 8));
          tmo_d   = TMO_LAST;
          if (cnt_q == CNT_LAST) begin
            state_d = S_WAITSPACE;
            cnt_d   = 4'd0;
            tmo_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else if (tmo_q == '0) begin
          state_d = S_HDR;
          err_evt = 1'b1;
        end else begin
          tmo_d = tmo_q - 32'd1;
        end
      end
      S_WAITSPACE: begin
        if (space_ok) state_d = S_BUS;
      end
      S_BUS: begin
        if (bad_q) begin
          state_d = S_RESP;
        end else if (!read_q && !write_q) begin
          read_d  = rnw_q;
          write_d = !rnw_q;
          be_d    = '1;
        end else if (!av.waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          be_d    = '0;
          if (read_q) rdata_d = av.readdata;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        push = 1'b1;
        if (bad_q) begin
          push_data = RESP_ERR;
          err_evt   = 1'b1;
          state_d   = S_HDR;
        end else if (!rnw_q) begin
          push_data = RESP_OK;
          state_d   = S_HDR;
        end else begin
          push_data = rdata_q[7:0];
          rdata_d   = rdata_q >> 8;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = 4'd0;
            state_d = S_HDR;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = S_HDR;
    endcase

    if (err_evt && err_q != 8'hFF) err_d = err_q + 8'd1;

    wptr_d = push ? wptr_q + PTR_ONE : wptr_q;
    rptr_d = pop  ? rptr_q + PTR_ONE : rptr_q;
  end

  // Control and datapath registers; reset drops any in-flight access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_HDR;
      rnw_q        <= 1'b0;
      bad_q        <= 1'b0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      be_q         <= '0;
      err_q        <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
    end else begin
      state_q      <= state_d;
      rnw_q        <= rnw_d;
      bad_q        <= bad_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      read_q       <= read_d;
      write_q      <= write_d;
      be_q         <= be_d;
      err_q        <= err_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
    end
  end

  // TX FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wptr_q[AW-1:0]] <= push_data;
  end

  assign av.address    = addr_q;
  assign av.read       = read_q;
  assign av.write      = write_q;
  assign av.writedata  = wdata_q;
  assign av.byteenable = be_q;
  assign busy          = (state_q != S_HDR) || !empty;
  assign err_cnt       = err_q;

endmodule

// File: tb/tb_uart_avalon_bridge.sv
// Directed bench for uart_avalon_bridge: UART host driver, TX byte monitor,
// Avalon slave with programmable wait states, table of frames plus corner cases.
module tb_uart_avalon_bridge;
  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       tx;
  logic       busy;
  logic [7:0] err_cnt;

  uart_avalon_bridge_if #(.DATA_W(32)) av ();

  uart_avalon_bridge #(
    .CLKS_PER_BIT (CPB),
    .DATA_W       (32),
    .NUM_REGS     (4),
    .BASE_ADDR    (32'h0),
    .TX_DEPTH     (16),
    .TIMEOUT_BITS (20)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .tx      (tx),
    .busy    (busy),
    .err_cnt (err_cnt),
    .av      (av)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  txq[$];
  logic [7:0]  mon_byte;
  int          stop_bad = 0;
  int          ws = 0;
  int          stall_cnt = 0;
  int          rd_cycles = 0;
  int          wr_cycles = 0;
  logic [31:0] last_addr = 32'hFFFF_FFFF;
  logic [31:0] last_wdata = 32'hFFFF_FFFF;
  logic [3:0]  last_be = 4'h0;
  logic [31:0] prev_addr = 32'h0;
  int          both_hi = 0;
  int          addr_unstable = 0;

  typedef struct {
    logic [7:0]  hdr;
    logic [31:0] payload;
    logic [31:0] rdata;
    int          wstates;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_resp;
    int          exp_n;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_tx(input int n);
    int k;
    k = 0;
    while (txq.size() < n && k < 6000) begin
      @(negedge clk);
      k++;
    end
    repeat (CPB * 12) @(negedge clk);
  endtask

  task automatic clear_bus_log();
    rd_cycles  = 0;
    wr_cycles  = 0;
    last_addr  = 32'hFFFF_FFFF;
    last_wdata = 32'hFFFF_FFFF;
    last_be    = 4'h0;
    txq.delete();
  endtask

  // UART receiver on the DUT TX line, sampling mid-bit.
  initial begin
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          mon_byte[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        if (tx !== 1'b1) stop_bad++;
        txq.push_back(mon_byte);
      end
    end
  end

  // Avalon slave: stalls each access for ws cycles, logs strobes.
  initial begin
    av.waitrequest = 1'b0;
    forever begin
      @(negedge clk);
      if (av.read || av.write) begin
        if (av.read && av.write) both_hi++;
        if (stall_cnt > 0 && av.address !== prev_addr) addr_unstable++;
        prev_addr  = av.address;
        if (av.read)  rd_cycles++;
        if (av.write) wr_cycles++;
        last_addr  = av.address;
        last_wdata = av.writedata;
        last_be    = av.byteenable;
        av.waitrequest = (stall_cnt < ws);
        stall_cnt++;
      end else begin
        stall_cnt      = 0;
        av.waitrequest = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h01, 32'h12345678, 32'h0,        0, 0, 1, 32'h4, 32'h12345678, 32'h000000A5, 1, 8'd0};
    vecs[1] = '{8'h82, 32'h0,        32'hDEADBEEF, 5, 6, 0, 32'h8, 32'h0,        32'hDEADBEEF, 4, 8'd0};
    vecs[2] = '{8'h85, 32'h0,        32'h0,        0, 0, 0, 32'h0, 32'h0,        32'h000000EE, 1, 8'd1};
    vecs[3] = '{8'h03, 32'h44332211, 32'h0,        2, 0, 3, 32'hC, 32'h44332211, 32'h000000A5, 1, 8'd1};
    vecs[4] = '{8'h80, 32'h0,        32'h0BADF00D, 0, 1, 0, 32'h0, 32'h0,        32'h0BADF00D, 4, 8'd1};
    vecs[5] = '{8'h7F, 32'hDDCCBBAA, 32'h0,        0, 0, 0, 32'h0, 32'h0,        32'h000000EE, 1, 8'd2};

    rx = 1'b1;
    av.readdata = '0;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_read", av.read, 1'b0);
    check("rst_write", av.write, 1'b0);
    check("rst_addr", av.address, 32'h0);
    check("rst_wdata", av.writedata, 32'h0);
    check("rst_be", av.byteenable, 4'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_cnt, 8'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      clear_bus_log();
      ws = vecs[i].wstates;
      av.readdata = vecs[i].rdata;
      send_byte(vecs[i].hdr, 1'b1);
      if (!vecs[i].hdr[7]) begin
        for (int j = 0; j < 4; j++) send_byte(vecs[i].payload[8*j +: 8], 1'b1);
      end
      wait_tx(vecs[i].exp_n);
      check($sformatf("v%0d_rd_cycles", i), rd_cycles, vecs[i].exp_rd);
      check($sformatf("v%0d_wr_cycles", i), wr_cycles, vecs[i].exp_wr);
      if (vecs[i].exp_rd + vecs[i].exp_wr > 0) begin
        check($sformatf("v%0d_addr", i), last_addr, vecs[i].exp_addr);
        check($sformatf("v%0d_be", i), last_be, 4'hF);
      end
      if (vecs[i].exp_wr > 0)
        check($sformatf("v%0d_wdata", i), last_wdata, vecs[i].exp_wdata);
      check($sformatf("v%0d_resp_len", i), txq.size(), vecs[i].exp_n);
      for (int j = 0; j < vecs[i].exp_n && j < txq.size(); j++)
        check($sformatf("v%0d_resp%0d", i, j), txq[j], vecs[i].exp_resp[8*j +: 8]);
      check($sformatf("v%0d_err", i), err_cnt, vecs[i].exp_err);
      check($sformatf("v%0d_busy", i), busy, 1'b0);
    end

    // Inter-byte timeout, then recovery with a clean frame.
    clear_bus_log();
    ws = 0;
    send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    repeat (25 * CPB) @(negedge clk);
    check("tmo_err", err_cnt, 8'd3);
    check("tmo_busy", busy, 1'b0);
    check("tmo_no_tx", txq.size(), 0);
    check("tmo_no_wr", wr_cycles, 0);
    send_byte(8'h02, 1'b1);
    send_byte(8'h0D, 1'b1);
    send_byte(8'hF0, 1'b1);
    send_byte(8'hFE, 1'b1);
    send_byte(8'hCA, 1'b1);
    wait_tx(1);
    check("rec_wr_cycles", wr_cycles, 1);
    check("rec_addr", last_addr, 32'h8);
    check("rec_wdata", last_wdata, 32'hCAFEF00D);
    check("rec_resp_len", txq.size(), 1);
    if (txq.size() > 0) check("rec_resp", txq[0], 8'hA5);
    check("rec_err", err_cnt, 8'd3);

    // Framing error on a payload byte aborts the frame.
    clear_bus_log();
    send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("ferr_err", err_cnt, 8'd4);
    check("ferr_busy", busy, 1'b0);
    check("ferr_no_wr", wr_cycles, 0);
    for (int i = 0; i < 300; i++) send_byte(8'h00, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("sat_err", err_cnt, 8'hFF);
    check("sat_no_tx", txq.size(), 0);

    // Reset while a read is stalled.
    clear_bus_log();
    ws = 1000;
    av.readdata = 32'h11111111;
    send_byte(8'h81, 1'b1);
    for (int k = 0; k < 3000 && !av.read; k++) @(negedge clk);
    check("mid_read_seen", av.read, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_read", av.read, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_err", err_cnt, 8'h0);
    check("mid_rst_tx", tx, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ws = 0;
    repeat (40 * CPB) @(negedge clk);
    check("mid_rst_no_tx", txq.size(), 0);
    check("mid_rst_idle_busy", busy, 1'b0);

    check("never_both_strobes", both_hi, 0);
    check("addr_stable", addr_unstable, 0);
    check("tx_stop_bits", stop_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
